dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the core's load/store port; it is the slave end of the memReq/memWrite request generated by the main decoder.
- Accepts one request at a time, inserts a configurable number of wait states, then performs a byte, half or word write, or an extended read.
- Reports misaligned accesses instead of executing them.
- Holds the core stalled through o_busy while a request is outstanding.

Parameters:
- ADDR_WIDTH, 10, word-index bits; storage depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between acceptance and response (0 allowed).

Ports:
- i_clk  input  1  clock; all logic on its rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_memReq  input  1  access request.
- i_memWrite  input  1  1 = store, 0 = load.
- i_size  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- i_isLoadSigned  input  1  0 = sign-extend load, 1 = zero-extend load (funct3[2]).
- i_addr  input  32  byte address.
- i_wdata  input  32  store data, right-aligned.
- o_rdata  output  32  extended load data.
- o_ready  output  1  one-cycle completion pulse.
- o_busy  output  1  request outstanding; core stalls.
- o_misaligned  output  1  valid with o_ready; access was rejected.

Behaviour:
- Reset:
  - Applied while i_rst_n=0 at a clock edge.
  - State returns to IDLE and the wait counter is cleared.
  - o_rdata=0, o_ready=0, o_busy=0, o_misaligned=0.
  - Storage contents are not reset.
  - Reset in WAIT or RESP aborts the access. A pending store is dropped because writes commit only in RESP.
- FSM, all outputs registered:
  - IDLE:
    - i_memReq=1 latches addr, size, wdata, write and signed into request registers.
    - Next state is WAIT if WAIT_CYCLES>0, with the counter loaded to WAIT_CYCLES-1; otherwise RESP.
    - o_busy=1 from the following cycle.
  - WAIT:
    - Counter decrements each cycle.
    - Moves to RESP in the cycle after the counter reads 0.
    - All inputs are ignored.
  - RESP:
    - Lasts one cycle: o_ready=1, o_busy=0, then next state is IDLE.
    - o_rdata and o_misaligned hold their values until the next RESP or reset.
- Latency: o_ready is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- Back-to-back requests:
  - The core drops i_memReq in the cycle o_ready is seen.
  - If i_memReq is still 1 in IDLE, it is a new request. No merging.
- Word index is i_addr[ADDR_WIDTH+1:2]. Higher bits are ignored, so addresses alias (wrap-around).
- Misaligned means any of:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11.
  - A misaligned access takes the same latency, asserts o_misaligned=1 with o_ready, does no write, and returns o_rdata=0.
- Store in RESP, other lanes untouched:
  - byte writes wdata[7:0] to lane addr[1:0];
  - half writes wdata[15:0] to bytes {addr[1],0} and {addr[1],1};
  - word writes the full word.
  - o_rdata on a store is 0.
- Load in RESP:
  - Selects the same lanes and right-aligns them.
  - Sign-extends from bit 7 or bit 15 when i_isLoadSigned=0; zero-extends when 1.
  - Word loads are unmodified.
- A write and a read to the same word never coexist, since there is one request at a time.

Test Plan:
- Reset then idle (WAIT_CYCLES=2):
  - hold i_rst_n=0 for 2 cycles, then release -> all outputs 0 and o_busy=0;
  - no o_ready while i_memReq=0.
- Word store/load:
  - store 0xDEADBEEF at 0x10, then load word at 0x10 -> o_ready 3 cycles after acceptance, o_rdata=0xDEADBEEF;
  - o_busy=1 on the 2 intervening cycles.
- Byte lanes:
  - store byte 0x80 at 0x13 over 0x11223344;
  - load word -> 0x80223344;
  - load byte signed at 0x13 -> 0xFFFFFF80;
  - load byte unsigned -> 0x00000080.
- Half:
  - store 0x8001 at 0x22;
  - load half signed at 0x22 -> 0xFFFF8001;
  - load half unsigned -> 0x00008001;
  - word at 0x20 has its low half unchanged.
- Misaligned:
  - word load at 0x0 preloaded to 0xCAFEF00D;
  - word store 0x12345678 at 0x02 -> o_misaligned=1, o_rdata=0;
  - word at 0x00 still 0xCAFEF00D;
  - half at 0x01 and size=11 both flag.
- Reset mid-access and alias:
  - store 0xAAAA5555 at 0x40, assert reset in the WAIT cycle -> word unchanged, FSM back in IDLE;
  - with ADDR_WIDTH=10, store at 0x1000 then load at 0x0000 -> same data;
  - WAIT_CYCLES=0 -> o_ready on the cycle after acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave on the core load/store port.
// Takes one request at a time, waits WAIT_CYCLES wait states, then answers with
// a one-cycle o_ready pulse. Stores of byte/half/word commit as RESP is left;
// loads return right-aligned, extended data. Misaligned or illegal-size
// accesses are flagged through o_misaligned and are not executed.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_memReq, i_memWrite  request strobe, 1 = store / 0 = load
//   i_size                00 byte, 01 half, 10 word, 11 illegal
//   i_isLoadSigned        0 = sign-extend load, 1 = zero-extend load
//   i_addr, i_wdata       byte address, right-aligned store data
//   o_rdata               extended load data (0 for stores / misaligned)
//   o_ready               completion pulse
//   o_busy                request outstanding
//   o_misaligned          access rejected, valid with o_ready
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_memReq; request fields latched on acceptance
// WAIT    | counting down wait states, inputs ignored
// RESP    | o_ready high for one cycle; pending store commits on exit
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [1:0]  i_size,
  input  logic        i_isLoadSigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WLOAD);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic                  uns_q;
  logic                  latch_req;

  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        mis_q, mis_d;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Upper address bits alias onto the same storage.
  logic unused_addr;
  assign unused_addr = ^i_addr[31:ADDR_WIDTH+2];

  // With zero wait states RESP is entered straight from IDLE, before the
  // request registers hold anything, so the live inputs are used there.
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [1:0]            cur_size;
  logic                  cur_write;
  logic                  cur_uns;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic                  cur_mis;
  logic [31:0]           rd_ext;

  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr  = i_addr[ADDR_WIDTH+1:0];
      cur_size  = i_size;
      cur_write = i_memWrite;
      cur_uns   = i_isLoadSigned;
    end else begin
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_write = write_q;
      cur_uns   = uns_q;
    end
  end

  always_comb begin
    rd_word = mem_q[cur_addr[ADDR_WIDTH+1:2]];
    case (cur_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (cur_size)
      2'b00:   cur_mis = 1'b0;
      2'b01:   cur_mis = cur_addr[0];
      2'b10:   cur_mis = (cur_addr[1:0] != 2'b00);
      default: cur_mis = 1'b1;
    endcase

    case (cur_size)
      2'b00:   rd_ext = cur_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = cur_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_memReq) begin
          latch_req = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_RESP);
    busy_d  = (state_d == ST_WAIT);
    rdata_d = rdata_q;
    mis_d   = mis_q;
    if (state_d == ST_RESP) begin
      mis_d   = cur_mis;
      rdata_d = (cur_mis || cur_write) ? 32'h0 : rd_ext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        addr_q  <= i_addr[ADDR_WIDTH+1:0];
        size_q  <= i_size;
        wdata_q <= i_wdata;
        write_q <= i_memWrite;
        uns_q   <= i_isLoadSigned;
      end
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
    end
  end

  // Store path: data replicated across lanes, byte enables pick the targets.
  logic [3:0]  wr_be;
  logic [31:0] wr_pat;
  logic        wr_en;

  always_comb begin
    case (size_q)
      2'b00: begin
        wr_be  = 4'b0001 << addr_q[1:0];
        wr_pat = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be  = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_pat = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be  = 4'b1111;
        wr_pat = wdata_q;
      end
    endcase
    wr_en = i_rst_n && (state_q == ST_RESP) && write_q && !mis_q;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem_q[addr_q[ADDR_WIDTH+1:2]][8*k +: 8] <= wr_pat[8*k +: 8];
      end
    end
  end

  assign o_rdata      = rdata_q;
  assign o_ready      = ready_q;
  assign o_busy       = busy_q;
  assign o_misaligned = mis_q;

endmodule
